coin_validator: RTL
===================

COIN_VALIDATOR -- requirements
Module: coin_validator

Interface
REQ-001 Parameters (name, default, meaning) SHALL be one per line, as follows:
- DEB, 3: consecutive equal samples required to change the debounced level.
- W5_MIN, 10 and W5_MAX, 20: inclusive width window, in cycles, for a Rs 5 coin.
- W10_MIN, 30 and W10_MAX, 45: inclusive width window, in cycles, for a Rs 10 coin.
- TMAX, 200: width at which a jam is declared.
- REJ_CYC, 8: reject-gate pulse length in cycles.
- GAP_CYC, 4: holdoff length in cycles after each coin.
REQ-002 The parameter legality rule SHALL be W5_MIN <= W5_MAX < W10_MIN <= W10_MAX < TMAX <= 255.
REQ-003 The clk port SHALL be an input, 1 bit wide: the single clock; all logic is on the rising edge.
REQ-004 The rst port SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 The coin_sense port SHALL be an input, 1 bit wide: raw optical sensor, high while a coin passes, asynchronous and bouncy.
REQ-006 The accept_en port SHALL be an input, 1 bit wide: downstream machine can take credit; when low, every coin is rejected.
REQ-007 The coin_code port SHALL be an output, 2 bits wide: 01 = Rs 5, 10 = Rs 10, 00 = none; it feeds the vending FSM coin input.
REQ-008 The reject_gate port SHALL be an output, 1 bit wide: drives the solenoid that diverts a coin to the return chute.
REQ-009 The jam port SHALL be an output, 1 bit wide: coin stuck in the sensor.
REQ-010 The busy port SHALL be an output, 1 bit wide: high whenever the FSM is not in IDLE.
REQ-011 The reject_cnt port SHALL be an output, 8 bits wide: count of rejected coins, saturating at 255.

Function
REQ-012 coin_sense SHALL pass through a two-flop synchronizer; the debounced level deb SHALL change only after DEB consecutive synchronized samples differ from it.
REQ-013 The FSM states SHALL be IDLE, MEASURE, CLASSIFY, EMIT, REJECT, JAM and GAP; all outputs SHALL be registered.
REQ-014 IDLE SHALL go to MEASURE on a deb rising edge, loading the width counter with 1; a deb already high on entry to IDLE SHALL NOT start a measurement.
REQ-015 MEASURE SHALL increment the width counter each cycle deb is high.
REQ-016 MEASURE SHALL go to CLASSIFY on the first cycle deb is low.
REQ-017 MEASURE SHALL go to JAM when the counter reaches TMAX.
REQ-018 CLASSIFY SHALL last one cycle, sampling accept_en and the width in that cycle.
REQ-019 CLASSIFY SHALL go to EMIT with code 01 if accept_en=1 and W5_MIN <= width <= W5_MAX.
REQ-020 CLASSIFY SHALL go to EMIT with code 10 if accept_en=1 and W10_MIN <= width <= W10_MAX.
REQ-021 CLASSIFY SHALL go to REJECT in every other case.
REQ-022 coin_code SHALL be nonzero for exactly one clock, during EMIT; otherwise it SHALL be 00.
REQ-023 EMIT SHALL be followed by GAP.
REQ-024 REJECT SHALL hold reject_gate=1 for exactly REJ_CYC cycles.
REQ-025 Entry to REJECT SHALL increment reject_cnt once, saturating at 255 with no wrap.
REQ-026 REJECT SHALL be followed by GAP.
REQ-027 JAM SHALL hold jam=1 and reject_gate=1 while deb is high.
REQ-028 JAM SHALL go to GAP on the first cycle deb is low, with jam cleared on that transition.
REQ-029 A jam SHALL NOT increment reject_cnt and SHALL NOT emit a code.
REQ-030 GAP SHALL last GAP_CYC cycles and SHALL ignore all deb edges, then return to IDLE.
REQ-031 At most one nonzero coin_code SHALL be produced per physical coin.
REQ-032 Two nonzero coin_code pulses SHALL be separated by at least GAP_CYC+3 cycles.
REQ-033 A bounce shorter than DEB cycles SHALL neither start nor end a measurement.
REQ-034 A change of accept_en outside the CLASSIFY cycle SHALL have no effect on the coin in flight.

Reset
REQ-035 While rst=0, the FSM SHALL be in IDLE and the synchronizer, deb, width counter and phase counters SHALL be cleared.
REQ-036 While rst=0, the outputs SHALL be coin_code=00, reject_gate=0, jam=0, busy=0 and reject_cnt=0.
REQ-037 rst assertion mid-operation (MEASURE, EMIT, REJECT or JAM) SHALL abandon the coin with no code emitted and no count change.
REQ-038 After release with coin_sense already high, no measurement SHALL start until coin_sense returns low and rises again.

Verification
REQ-039 The bench SHALL cover: clean 15-cycle pulse with accept_en=1 -> coin_code=01 for one cycle, reject_cnt unchanged.
REQ-040 The bench SHALL cover: 40-cycle pulse with 2-cycle bounces on both edges and accept_en=1 -> a single coin_code=10 pulse.
REQ-041 The bench SHALL cover: 25-cycle pulse -> coin_code stays 00, reject_gate high for 8 cycles, reject_cnt 0 -> 1.
REQ-042 The bench SHALL cover: 15-cycle pulse with accept_en=0 at CLASSIFY -> reject path taken and coin_code stays 00.
REQ-043 The bench SHALL cover: coin_sense held high for 300 cycles -> jam=1 from width 200 until deb falls, then GAP and IDLE, reject_cnt unchanged.
REQ-044 The bench SHALL cover: reject_cnt preloaded to 255 by 255 rejects, then one more reject -> reject_cnt stays 255.
REQ-045 The bench SHALL cover: rst pulsed low during MEASURE -> all outputs 0, and the next valid coin classifies normally.

Source files
------------

// File: rtl/coin_validator.sv
// Coin validator: synchronizes and debounces the optical coin sensor, measures the
// pulse width, and classifies each coin as Rs 5, Rs 10, reject or jam.
module coin_validator #(
  parameter int DEB     = 3,
  parameter int W5_MIN  = 10,
  parameter int W5_MAX  = 20,
  parameter int W10_MIN = 30,
  parameter int W10_MAX = 45,
  parameter int TMAX    = 200,
  parameter int REJ_CYC = 8,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       accept_en,
  output logic [1:0] coin_code,
  output logic       reject_gate,
  output logic       jam,
  output logic       busy,
  output logic [7:0] reject_cnt
);

  // Legal parameters satisfy W5_MIN <= W5_MAX < W10_MIN <= W10_MAX < TMAX <= 255.
  localparam logic [7:0] DEB_M1   = 8'(DEB - 1);
  localparam logic [7:0] W5_LO    = 8'(W5_MIN);
  localparam logic [7:0] W5_HI    = 8'(W5_MAX);
  localparam logic [7:0] W10_LO   = 8'(W10_MIN);
  localparam logic [7:0] W10_HI   = 8'(W10_MAX);
  localparam logic [7:0] TMAX_L   = 8'(TMAX);
  localparam logic [7:0] REJ_M1   = 8'(REJ_CYC - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_CYC - 1);
  localparam logic [7:0] CNT_SAT  = 8'd255;

  typedef enum logic [2:0] {
    IDLE, MEASURE, CLASSIFY, EMIT, REJECT, JAM, GAP
  } state_t;

  state_t     state_q, state_d;
  logic       s1_q, s2_q;
  logic       deb_q, deb_d, deb_prev_q;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic [7:0] width_q, width_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [1:0] code_q, code_d;
  logic       reject_q, reject_d;
  logic       jam_q, jam_d;
  logic       busy_q, busy_d;
  logic       deb_rise;
  logic       in_w5, in_w10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      width_q    <= '0;
      phase_q    <= '0;
      rcnt_q     <= '0;
      code_q     <= 2'b00;
      reject_q   <= 1'b0;
      jam_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= coin_sense;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      width_q    <= width_d;
      phase_q    <= phase_d;
      rcnt_q     <= rcnt_d;
      code_q     <= code_d;
      reject_q   <= reject_d;
      jam_q      <= jam_d;
      busy_q     <= busy_d;
    end
  end

  // Debounce: the level flips only after DEB consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (s2_q != deb_q) begin
      if (deb_cnt_q == DEB_M1) begin
        deb_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  // Once the synchronizer holds real samples, arm only after a confirmed low level,
  // so a coin already in the sensor at reset release is never measured.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & ~s2_q & ~deb_q);
  end

  assign deb_rise = deb_q & ~deb_prev_q & armed_q;
  assign in_w5    = (width_q >= W5_LO)  && (width_q <= W5_HI);
  assign in_w10   = (width_q >= W10_LO) && (width_q <= W10_HI);

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    phase_d = phase_q;
    rcnt_d  = rcnt_q;
    code_d  = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (deb_rise) begin
          state_d = MEASURE;
          width_d = 8'd1;
        end
      end
      MEASURE: begin
        if (!deb_q) begin
          state_d = CLASSIFY;
        end else begin
          width_d = width_q + 8'd1;
          if (width_q + 8'd1 == TMAX_L) state_d = JAM;
        end
      end
      CLASSIFY: begin
        if (accept_en && in_w5) begin
          state_d = EMIT;
          code_d  = 2'b01;
        end else if (accept_en && in_w10) begin
          state_d = EMIT;
          code_d  = 2'b10;
        end else begin
          state_d = REJECT;
          phase_d = REJ_M1;
          if (rcnt_q != CNT_SAT) rcnt_d = rcnt_q + 8'd1;
        end
      end
      EMIT: begin
        state_d = GAP;
        phase_d = GAP_M1;
      end
      REJECT: begin
        if (phase_q == 8'd0) begin
          state_d = GAP;
          phase_d = GAP_M1;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      JAM: begin
        if (!deb_q) begin
          state_d = GAP;
          phase_d = GAP_M1;
        end
      end
      GAP: begin
        if (phase_q == 8'd0) state_d = IDLE;
        else phase_d = phase_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so each is a clean register aligned with state_q.
    reject_d = (state_d == REJECT) || (state_d == JAM);
    jam_d    = (state_d == JAM);
    busy_d   = (state_d != IDLE);
  end

  assign coin_code   = code_q;
  assign reject_gate = reject_q;
  assign jam         = jam_q;
  assign busy        = busy_q;
  assign reject_cnt  = rcnt_q;

endmodule
